// File: rtl/pll_lock_monitor_if.sv
// Status/control bundle between the PLL lock supervisor and its consumer.
// The master side is the supervisor: it samples the toggle and restart, and drives the status.
interface pll_lock_monitor_if #(
    parameter int CNT_W = 12
);
    logic             mon_toggle;
    logic             restart;
    logic             pll_rst;
    logic             locked;
    logic             fail;
    logic             lost_lock;
    logic [1:0]       retry_cnt;
    logic [CNT_W-1:0] last_count;

    modport master (
        input  mon_toggle, restart,
        output pll_rst, locked, fail, lost_lock, retry_cnt, last_count
    );

    modport slave (
        output mon_toggle, restart,
        input  pll_rst, locked, fail, lost_lock, retry_cnt, last_count
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// PLL lock supervisor on the reference clock: pulses the PLL reset, counts feedback
// toggles per window to qualify lock, retries on bad windows and reports locked/fail.
module pll_lock_monitor #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 512,
    parameter int WINDOW        = 256,
    parameter int EXP_CNT       = 32,
    parameter int TOL           = 2,
    parameter int LOCK_WINDOWS  = 4,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 12
) (
    input  logic               clk,
    input  logic               rst,
    pll_lock_monitor_if.master bus
);
    localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES)
                          ? ((RST_CYCLES > WINDOW) ? RST_CYCLES : WINDOW)
                          : ((SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LO  = CNT_W'(EXP_CNT - TOL);
    localparam logic [CNT_W-1:0] CNT_HI  = CNT_W'(EXP_CNT + TOL);

    typedef enum logic [2:0] {RESET_PLL, SETTLE, MEASURE, LOCKED, FAIL} state_t;

    state_t            state, state_nx;
    logic [PH_W-1:0]   ph_cnt, ph_cnt_nx;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_nx, edge_sum;
    logic [CNT_W-1:0]  last_q, last_nx;
    logic [GOOD_W-1:0] good_cnt, good_nx;
    logic [1:0]        retry_q, retry_nx;
    logic              lost_q, lost_nx;
    logic              sync1, sync2, hist;
    logic              tog_edge, win_end, good_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= bus.mon_toggle;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign tog_edge = sync2 ^ hist;
    assign win_end  = ((state == MEASURE) || (state == LOCKED)) && (ph_cnt == PH_W'(WINDOW - 1));
    // Window-end decisions use the count including this cycle's edge; saturates, never wraps.
    assign edge_sum = (tog_edge && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
    assign good_win = (edge_sum >= CNT_LO) && (edge_sum <= CNT_HI);

    always_comb begin
        state_nx    = state;
        ph_cnt_nx   = ph_cnt + 1'b1;
        edge_cnt_nx = '0;
        last_nx     = last_q;
        good_nx     = good_cnt;
        retry_nx    = retry_q;
        lost_nx     = 1'b0;
        case (state)
            RESET_PLL: if (ph_cnt == PH_W'(RST_CYCLES - 1)) state_nx = SETTLE;
            SETTLE: begin
                if (ph_cnt == PH_W'(SETTLE_CYCLES - 1)) begin
                    state_nx = MEASURE;
                    good_nx  = '0;
                end
            end
            MEASURE, LOCKED: begin
                edge_cnt_nx = edge_sum;
                if (win_end) begin
                    edge_cnt_nx = '0;
                    last_nx     = edge_sum;
                    if (state == LOCKED) begin
                        if (!good_win) begin
                            lost_nx  = 1'b1;
                            retry_nx = '0;
                            state_nx = RESET_PLL;
                        end
                    end else if (good_win) begin
                        good_nx = good_cnt + 1'b1;
                        if (good_cnt + 1'b1 == GOOD_W'(LOCK_WINDOWS)) state_nx = LOCKED;
                    end else if (retry_q == 2'(MAX_RETRIES)) begin
                        state_nx = FAIL;
                    end else begin
                        retry_nx = retry_q + 1'b1;
                        state_nx = RESET_PLL;
                    end
                end
            end
            FAIL:    ph_cnt_nx = '0;
            default: state_nx = RESET_PLL;
        endcase
        if (bus.restart) begin
            state_nx    = RESET_PLL;
            retry_nx    = '0;
            good_nx     = '0;
            edge_cnt_nx = '0;
            lost_nx     = 1'b0;
        end
        if ((state_nx != state) || win_end || bus.restart) ph_cnt_nx = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_PLL;
            ph_cnt   <= '0;
            edge_cnt <= '0;
            last_q   <= '0;
            good_cnt <= '0;
            retry_q  <= '0;
            lost_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            ph_cnt   <= ph_cnt_nx;
            edge_cnt <= edge_cnt_nx;
            last_q   <= last_nx;
            good_cnt <= good_nx;
            retry_q  <= retry_nx;
            lost_q   <= lost_nx;
        end
    end

    assign bus.pll_rst    = (state == RESET_PLL) || (state == FAIL);
    assign bus.locked     = (state == LOCKED);
    assign bus.fail       = (state == FAIL);
    assign bus.lost_lock  = lost_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.last_count = last_q;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: a phase-level model predicts every output change per scenario,
// and a monitor matches each observed output change against the predicted queue.
module tb_pll_lock_monitor;
    localparam int CW     = 12;
    localparam int RSTC   = 16;
    localparam int SETC   = 512;
    localparam int WIN    = 256;
    localparam int LO     = 30;
    localparam int HI     = 34;
    localparam int VMAX   = 8000;
    localparam logic [17:0] RST_VEC = 18'h20000;

    typedef struct {
        int          cyc;
        logic [17:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pll_lock_monitor_if #(.CNT_W(CW)) bus ();

    pll_lock_monitor #(
        .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC), .WINDOW(WIN), .EXP_CNT(32), .TOL(2),
        .LOCK_WINDOWS(4), .MAX_RETRIES(3), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    ev_t         expq[$];
    logic        v[0:VMAX-1];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [17:0] prev;
    logic [17:0] mcur;
    int          mN;

    function automatic logic [17:0] dut_vec();
        return {bus.pll_rst, bus.locked, bus.fail, bus.lost_lock, bus.retry_cnt, bus.last_count};
    endfunction

    function automatic logic getv(input int c);
        return (c <= 0) ? 1'b0 : v[c];
    endfunction

    // Toggle transitions reach the counter two cycles late through the synchronizer.
    function automatic int edges(input int a, input int b);
        int n = 0;
        for (int c = a + 1; c <= b; c++)
            if (getv(c - 2) != getv(c - 3)) n++;
        return (n > 4095) ? 4095 : n;
    endfunction

    function automatic void mset(input int c, input logic p, input logic l, input logic f,
                                 input logic ll, input int r, input int lc);
        logic [17:0] vec;
        ev_t e;
        vec = {p, l, f, ll, 2'(r), 12'(lc)};
        if (c <= mN && vec != mcur) begin
            e.cyc = c;
            e.vec = vec;
            expq.push_back(e);
            mcur = vec;
        end
    endfunction

    task automatic build_model(input int N, input int R);
        int t, retry, last, good, e, cnt;
        bit lk, done, again;
        mN = N; mcur = RST_VEC; expq.delete();
        t = 0; retry = 0; last = 0; done = 1'b0;
        while (!done) begin
            t += RSTC;
            if (t > N) break;
            mset(t, 0, 0, 0, 0, retry, last);
            t += SETC;
            if (t > N) break;
            good = 0; lk = 1'b0; again = 1'b0;
            while (!again && !done) begin
                e = t + WIN;
                if (e > N) begin
                    done = 1'b1;
                end else begin
                    cnt = edges(t, e);
                    last = cnt;
                    if (cnt >= LO && cnt <= HI) begin
                        if (!lk) begin
                            good++;
                            if (good == 4) lk = 1'b1;
                        end
                        mset(e, 0, lk, 0, 0, retry, last);
                    end else if (lk) begin
                        retry = 0;
                        mset(e, 1, 0, 0, 1, 0, last);
                        mset(e + 1, 1, 0, 0, 0, 0, last);
                        again = 1'b1;
                    end else if (retry == 3) begin
                        mset(e, 1, 0, 1, 0, 3, last);
                        if (R > e) begin
                            retry = 0;
                            mset(R, 1, 0, 0, 0, 0, last);
                            e = R;
                            again = 1'b1;
                        end else begin
                            done = 1'b1;
                        end
                    end else begin
                        retry++;
                        mset(e, 1, 0, 0, 0, retry, last);
                        again = 1'b1;
                    end
                    t = e;
                end
            end
        end
    endtask

    task automatic fill_period(input int P, input int ph, input int stop);
        v[0] = 1'b0;
        for (int c = 1; c < VMAX; c++)
            v[c] = (c >= stop) ? v[c - 1] : 1'(((c + ph) / P) % 2);
    endtask

    task automatic fill_jitter(input int stop);
        int c = 1;
        logic lvl = 1'b0;
        int len;
        v[0] = 1'b0;
        while (c < VMAX) begin
            len = $urandom_range(9, 7);
            for (int k = 0; k < len && c < VMAX; k++) begin
                v[c] = (c >= stop) ? v[c - 1] : lvl;
                c++;
            end
            lvl = ~lvl;
        end
    endtask

    task automatic run(input int N, input int R);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++;
            $display("FAIL async_reset_values got=%h expected=%h", dut_vec(), RST_VEC);
        end
        bus.mon_toggle = 1'b0;
        bus.restart = 1'b0;
        repeat (3) @(negedge clk);
        build_model(N, R);
        prev = RST_VEC;
        cyc = 0;
        bus.mon_toggle = v[1];
        rst = 1'b0;
        mon_en = 1'b1;
        for (int c = 1; c <= N; c++) begin
            @(posedge clk);
            cyc = c;
            @(negedge clk);
            bus.mon_toggle = v[c + 1];
            bus.restart = (c + 1 == R);
        end
        #2 mon_en = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=0 expected=%0d next_cyc=%0d", expq.size(), expq[0].cyc);
            expq.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [17:0] cur;
        ev_t e;
        if (mon_en) begin
            cur = dut_vec();
            if (cur !== prev) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
                end else begin
                    e = expq.pop_front();
                    if (e.cyc != cyc || e.vec !== cur) begin
                        failures++;
                        $display("FAIL event got cyc=%0d vec=%h expected cyc=%0d vec=%h",
                                 cyc, cur, e.cyc, e.vec);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        bus.mon_toggle = 1'b0;
        bus.restart = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal toggle every 8 cycles: lock at 1552 with last_count 32.
        fill_period(8, 0, VMAX);
        run(1700, 0);
        checks++;
        if (bus.locked !== 1'b1 || bus.last_count !== 12'd32) begin
            failures++;
            $display("FAIL nominal_lock got locked=%b count=%0d expected locked=1 count=32",
                     bus.locked, bus.last_count);
        end

        // Stuck toggle: retries then fail, restart in FAIL with a good toggle relocks.
        for (int c = 0; c < VMAX; c++) v[c] = 1'b0;
        for (int c = 3200; c < VMAX; c++) v[c] = 1'(((c - 3200) / 8) % 2);
        run(4900, 3200);

        // Too fast (every 7): always bad, ends in FAIL with count 36/37.
        fill_period(7, $urandom_range(6, 0), VMAX);
        run(3300, 0);
        checks++;
        if (bus.fail !== 1'b1 || (bus.last_count !== 12'd36 && bus.last_count !== 12'd37)) begin
            failures++;
            $display("FAIL fast_toggle got fail=%b count=%0d expected fail=1 count=36..37",
                     bus.fail, bus.last_count);
        end

        // Jittered nominal toggle then stopped after lock: lost_lock path, ends in SETTLE.
        fill_jitter(1700);
        run(2000, 0);

        // Random period/phase from SETTLE-interrupted state.
        for (int k = 0; k < 2; k++) begin
            fill_period($urandom_range(10, 6), $urandom_range(9, 0), VMAX);
            run(3000, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
